// File: rtl/snake_ctrl_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : snake_ctrl_master_if
//  Purpose  : Avalon-MM write bus between the snake controller and the
//             VGA snake display register file.
//  Revision : 1.0 - initial release
// ============================================================================
interface snake_ctrl_master_if;
    logic        chipselect;
    logic        write;
    logic [2:0]  address;
    logic [15:0] writedata;
    logic        waitrequest;

    modport master (
        output chipselect,
        output write,
        output address,
        output writedata,
        input  waitrequest
    );

    modport slave (
        input  chipselect,
        input  write,
        input  address,
        input  writedata,
        output waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/snake_ctrl_master.sv
`default_nettype none
// ============================================================================
//  Module   : snake_ctrl_master
//  Purpose  : Snake game controller; advances the head every FRAMES_PER_STEP
//             VSYNC frames and pushes length/x/y to the display over Avalon-MM.
//  Revision : 1.0 - initial release
// ============================================================================
module snake_ctrl_master #(
    parameter int FRAMES_PER_STEP = 4,
    parameter int GRID_W          = 106,
    parameter int GRID_H          = 80,
    parameter int MAX_LEN         = 6,
    parameter int INIT_X          = 50,
    parameter int INIT_Y          = 40,
    parameter int INIT_LEN        = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       vga_vs_n,
    input  logic                       dir_valid,
    input  logic [1:0]                 dir,
    input  logic                       grow,
    input  logic                       restart,
    snake_ctrl_master_if.master        bus,
    output logic [15:0]                head_x,
    output logic [15:0]                head_y,
    output logic [15:0]                length,
    output logic                       game_over,
    output logic                       overrun
);

    localparam logic [2:0] c_S_INIT   = 3'd0;
    localparam logic [2:0] c_S_IDLE   = 3'd1;
    localparam logic [2:0] c_S_STEP   = 3'd2;
    localparam logic [2:0] c_S_WR_LEN = 3'd3;
    localparam logic [2:0] c_S_WR_X   = 3'd4;
    localparam logic [2:0] c_S_WR_Y   = 3'd5;
    localparam logic [2:0] c_S_DEAD   = 3'd6;

    localparam logic [1:0] c_UP    = 2'd0;
    localparam logic [1:0] c_RIGHT = 2'd1;
    localparam logic [1:0] c_DOWN  = 2'd2;

    localparam logic [2:0]  c_ADDR_X    = 3'd0;
    localparam logic [2:0]  c_ADDR_Y    = 3'd1;
    localparam logic [2:0]  c_ADDR_LEN  = 3'd2;

    localparam logic [7:0]  c_LAST_FRAME = 8'(FRAMES_PER_STEP - 1);
    localparam logic [15:0] c_X_MAX      = 16'(GRID_W - 1);
    localparam logic [15:0] c_Y_MAX      = 16'(GRID_H - 1);
    localparam logic [15:0] c_MAX_LEN    = 16'(MAX_LEN);
    localparam logic [15:0] c_INIT_X     = 16'(INIT_X);
    localparam logic [15:0] c_INIT_Y     = 16'(INIT_Y);
    localparam logic [15:0] c_INIT_LEN   = 16'(INIT_LEN);

    logic        r_vs_meta;
    logic        r_vs_sync;
    logic        r_vs_prev;
    logic        w_tick;

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;

    logic [7:0]  r_frame_cnt;
    logic        r_step_pending;
    logic        r_grow_pending;
    logic        r_overrun;
    logic [1:0]  r_heading;

    logic [15:0] r_head_x;
    logic [15:0] r_head_y;
    logic [15:0] r_length;

    logic        r_cs;
    logic [2:0]  r_addr;
    logic [15:0] r_wdata;

    logic [15:0] w_cand_x;
    logic [15:0] w_cand_y;
    logic        w_out_of_range;
    logic [15:0] w_len_inc;
    logic        w_step_ok;
    logic        w_restart_go;
    logic [15:0] w_hx_next;
    logic [15:0] w_hy_next;
    logic [15:0] w_len_next;

    // VSYNC crossing; idle level is high so reset never fakes an edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_meta <= 1'b1;
            r_vs_sync <= 1'b1;
            r_vs_prev <= 1'b1;
        end else begin
            r_vs_meta <= vga_vs_n;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
        end
    end

    assign w_tick = r_vs_prev & ~r_vs_sync;

    // Candidate head position; bounds are checked before any arithmetic wraps.
    always_comb begin
        w_cand_x       = r_head_x;
        w_cand_y       = r_head_y;
        w_out_of_range = 1'b0;
        case (r_heading)
            c_UP: begin
                w_out_of_range = (r_head_y == 16'd0);
                w_cand_y       = r_head_y - 16'd1;
            end
            c_RIGHT: begin
                w_out_of_range = (r_head_x >= c_X_MAX);
                w_cand_x       = r_head_x + 16'd1;
            end
            c_DOWN: begin
                w_out_of_range = (r_head_y >= c_Y_MAX);
                w_cand_y       = r_head_y + 16'd1;
            end
            default: begin
                w_out_of_range = (r_head_x == 16'd0);
                w_cand_x       = r_head_x - 16'd1;
            end
        endcase
    end

    assign w_len_inc    = (r_length < c_MAX_LEN) ? (r_length + 16'd1) : r_length;
    assign w_step_ok    = (r_state == c_S_STEP) && !w_out_of_range;
    assign w_restart_go = (r_state == c_S_DEAD) && restart;

    always_comb begin
        w_hx_next  = r_head_x;
        w_hy_next  = r_head_y;
        w_len_next = r_length;
        if (w_restart_go) begin
            w_hx_next  = c_INIT_X;
            w_hy_next  = c_INIT_Y;
            w_len_next = c_INIT_LEN;
        end else if (w_step_ok) begin
            w_hx_next  = w_cand_x;
            w_hy_next  = w_cand_y;
            w_len_next = r_grow_pending ? w_len_inc : r_length;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_INIT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_INIT:   w_state_next = c_S_WR_LEN;
            c_S_IDLE:   if (r_step_pending) w_state_next = c_S_STEP;
            c_S_STEP:   w_state_next = w_out_of_range ? c_S_DEAD : c_S_WR_LEN;
            c_S_WR_LEN: if (!bus.waitrequest) w_state_next = c_S_WR_X;
            c_S_WR_X:   if (!bus.waitrequest) w_state_next = c_S_WR_Y;
            c_S_WR_Y:   if (!bus.waitrequest) w_state_next = c_S_IDLE;
            c_S_DEAD:   if (restart) w_state_next = c_S_INIT;
            default:    w_state_next = c_S_INIT;
        endcase
    end

    // Frame pacing: one pending step at most, a second wrap flags overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_cnt    <= 8'd0;
            r_step_pending <= 1'b0;
            r_overrun      <= 1'b0;
        end else if (r_state == c_S_DEAD) begin
            r_step_pending <= 1'b0;
            if (restart) begin
                r_frame_cnt <= 8'd0;
                r_overrun   <= 1'b0;
            end
        end else begin
            if (r_state == c_S_STEP) begin
                r_step_pending <= 1'b0;
            end
            if (w_tick) begin
                if (r_frame_cnt == c_LAST_FRAME) begin
                    r_frame_cnt <= 8'd0;
                    if (r_step_pending && (r_state != c_S_STEP)) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_step_pending <= 1'b1;
                    end
                end else begin
                    r_frame_cnt <= r_frame_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_heading      <= c_RIGHT;
            r_grow_pending <= 1'b0;
        end else begin
            if (w_restart_go) begin
                r_heading <= c_RIGHT;
            end else if (dir_valid && (dir != (r_heading ^ 2'b10))) begin
                r_heading <= dir;
            end

            if (w_restart_go) begin
                r_grow_pending <= 1'b0;
            end else if (grow) begin
                r_grow_pending <= 1'b1;
            end else if (w_step_ok) begin
                r_grow_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head_x <= c_INIT_X;
            r_head_y <= c_INIT_Y;
            r_length <= c_INIT_LEN;
        end else begin
            r_head_x <= w_hx_next;
            r_head_y <= w_hy_next;
            r_length <= w_len_next;
        end
    end

    // Bus outputs are loaded from the state being entered, so they hold
    // steady for as long as waitrequest keeps the FSM in a write state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cs    <= 1'b0;
            r_addr  <= 3'd0;
            r_wdata <= 16'd0;
        end else begin
            case (w_state_next)
                c_S_WR_LEN: begin
                    r_cs    <= 1'b1;
                    r_addr  <= c_ADDR_LEN;
                    r_wdata <= w_len_next;
                end
                c_S_WR_X: begin
                    r_cs    <= 1'b1;
                    r_addr  <= c_ADDR_X;
                    r_wdata <= w_hx_next;
                end
                c_S_WR_Y: begin
                    r_cs    <= 1'b1;
                    r_addr  <= c_ADDR_Y;
                    r_wdata <= w_hy_next;
                end
                default: begin
                    r_cs    <= 1'b0;
                    r_addr  <= 3'd0;
                    r_wdata <= 16'd0;
                end
            endcase
        end
    end

    assign bus.chipselect = r_cs;
    assign bus.write      = r_cs;
    assign bus.address    = r_addr;
    assign bus.writedata  = r_wdata;

    assign head_x    = r_head_x;
    assign head_y    = r_head_y;
    assign length    = r_length;
    assign game_over = (r_state == c_S_DEAD);
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_snake_ctrl_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_snake_ctrl_master
//  Purpose  : Scoreboard bench for snake_ctrl_master Avalon write bursts.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_snake_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        vga_vs_n;
    logic        dir_valid;
    logic [1:0]  dir;
    logic        grow;
    logic        restart;
    logic [15:0] head_x;
    logic [15:0] head_y;
    logic [15:0] length;
    logic        game_over;
    logic        overrun;

    snake_ctrl_master_if bus ();

    snake_ctrl_master #(
        .FRAMES_PER_STEP (4),
        .GRID_W          (106),
        .GRID_H          (80),
        .MAX_LEN         (6),
        .INIT_X          (50),
        .INIT_Y          (40),
        .INIT_LEN        (2)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .vga_vs_n  (vga_vs_n),
        .dir_valid (dir_valid),
        .dir       (dir),
        .grow      (grow),
        .restart   (restart),
        .bus       (bus),
        .head_x    (head_x),
        .head_y    (head_y),
        .length    (length),
        .game_over (game_over),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int          checks   = 0;
    int          errors   = 0;
    int          wr_count = 0;
    logic [18:0] exp_q[$];
    logic [18:0] mon_exp;

    // Each completed transfer is popped against the scoreboard.
    always @(negedge clk) begin
        if (reset_n && bus.chipselect && bus.write && !bus.waitrequest) begin
            wr_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL bus_write unexpected: addr=%0d data=0x%04h, required no write",
                         bus.address, bus.writedata);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({bus.address, bus.writedata} !== mon_exp) begin
                    errors++;
                    $display("FAIL bus_write got addr=%0d data=0x%04h, required addr=%0d data=0x%04h",
                             bus.address, bus.writedata, mon_exp[18:16], mon_exp[15:0]);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic vs_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            vga_vs_n = 1'b0;
            cycles(3);
            vga_vs_n = 1'b1;
            cycles(9);
        end
    endtask

    task automatic push_burst(input int len, input int x, input int y);
        exp_q.push_back({3'd2, 16'(len)});
        exp_q.push_back({3'd0, 16'(x)});
        exp_q.push_back({3'd1, 16'(y)});
    endtask

    task automatic strobe_dir(input logic [1:0] d);
        dir       = d;
        dir_valid = 1'b1;
        cycles(1);
        dir_valid = 1'b0;
    endtask

    task automatic wait_drain(output int left);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycles(1);
        cycles(2);
        left = exp_q.size();
    endtask

    task automatic test_reset;
        int base;
        reset_n = 1'b0;
        vga_vs_n = 1'b1; dir_valid = 1'b0; dir = 2'd0; grow = 1'b0; restart = 1'b0;
        bus.waitrequest = 1'b0;
        cycles(3);
        @(negedge clk);
        checks++; if (bus.chipselect !== 1'b0 || bus.write !== 1'b0) begin errors++;
            $display("FAIL reset_bus cs=%b wr=%b, required 0 0", bus.chipselect, bus.write); end
        checks++; if (bus.address !== 3'd0 || bus.writedata !== 16'd0) begin errors++;
            $display("FAIL reset_addr_data addr=%0d data=0x%04h, required 0 0x0000", bus.address, bus.writedata); end
        checks++; if (head_x !== 16'd50 || head_y !== 16'd40 || length !== 16'd2) begin errors++;
            $display("FAIL reset_head x=%0d y=%0d len=%0d, required 50 40 2", head_x, head_y, length); end
        checks++; if (game_over !== 1'b0 || overrun !== 1'b0) begin errors++;
            $display("FAIL reset_flags go=%b ov=%b, required 0 0", game_over, overrun); end
        push_burst(2, 50, 40);
        base = wr_count;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycles(4);
        checks++; if (wr_count - base !== 3 || bus.write !== 1'b0) begin errors++;
            $display("FAIL init_burst_len writes=%0d write=%b, required 3 0", wr_count - base, bus.write); end
        base = wr_count;
        cycles(20);
        checks++; if (wr_count !== base) begin errors++;
            $display("FAIL idle_quiet writes=%0d, required 0", wr_count - base); end
    endtask

    task automatic test_steps;
        int left;
        int base;
        base = wr_count;
        push_burst(2, 51, 40);
        push_burst(2, 52, 40);
        vs_pulses(8);
        wait_drain(left);
        checks++; if (left !== 0) begin errors++;
            $display("FAIL steps_drain left=%0d, required 0", left); end
        checks++; if (wr_count - base !== 6) begin errors++;
            $display("FAIL steps_count writes=%0d, required 6", wr_count - base); end
        checks++; if (head_x !== 16'h0034 || head_y !== 16'h0028) begin errors++;
            $display("FAIL steps_head x=0x%04h y=0x%04h, required 0x0034 0x0028", head_x, head_y); end
        checks++; if (overrun !== 1'b0) begin errors++;
            $display("FAIL steps_overrun got %b, required 0", overrun); end
    endtask

    task automatic test_turn;
        int left;
        push_burst(2, 52, 39);
        strobe_dir(2'd3);
        strobe_dir(2'd0);
        vs_pulses(4);
        wait_drain(left);
        checks++; if (left !== 0) begin errors++;
            $display("FAIL turn_drain left=%0d, required 0", left); end
        checks++; if (head_y !== 16'h0027 || head_x !== 16'h0034) begin errors++;
            $display("FAIL turn_head x=0x%04h y=0x%04h, required 0x0034 0x0027", head_x, head_y); end
    endtask

    task automatic test_waitrequest;
        int  left;
        int  held;
        bit  found;
        push_burst(2, 52, 38);
        vs_pulses(3);
        vga_vs_n = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (bus.write && bus.address == 3'd2) found = 1'b1;
        end
        checks++; if (!found) begin errors++;
            $display("FAIL stall_start got no length write, required one within 40 cycles"); end
        @(posedge clk); #1;
        bus.waitrequest = 1'b1;
        held = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.write && bus.chipselect && bus.address == 3'd0 && bus.writedata == 16'd52) held++;
            @(posedge clk); #1;
        end
        checks++; if (exp_q.size() !== 2) begin errors++;
            $display("FAIL stall_pending queue=%0d, required 2", exp_q.size()); end
        bus.waitrequest = 1'b0;
        @(negedge clk);
        if (bus.write && bus.chipselect && bus.address == 3'd0 && bus.writedata == 16'd52) held++;
        checks++; if (held !== 6) begin errors++;
            $display("FAIL stall_stable cycles=%0d, required 6", held); end
        @(posedge clk); #1;
        vga_vs_n = 1'b1;
        cycles(8);
        wait_drain(left);
        checks++; if (left !== 0 || head_y !== 16'd38) begin errors++;
            $display("FAIL stall_done left=%0d y=%0d, required 0 38", left, head_y); end
    endtask

    task automatic test_grow;
        int left;
        int len;
        for (int s = 0; s < 6; s++) begin
            grow = 1'b1;
            cycles(1);
            grow = 1'b0;
            len = (3 + s > 6) ? 6 : 3 + s;
            push_burst(len, 52, 37 - s);
            vs_pulses(4);
        end
        wait_drain(left);
        checks++; if (left !== 0) begin errors++;
            $display("FAIL grow_drain left=%0d, required 0", left); end
        checks++; if (length !== 16'h0006 || head_y !== 16'd32) begin errors++;
            $display("FAIL grow_len len=0x%04h y=%0d, required 0x0006 32", length, head_y); end
    endtask

    task automatic test_dead;
        int left;
        int base;
        strobe_dir(2'd1);
        for (int x = 53; x <= 105; x++) begin
            push_burst(6, x, 32);
            vs_pulses(4);
        end
        wait_drain(left);
        checks++; if (left !== 0 || head_x !== 16'd105) begin errors++;
            $display("FAIL edge_reach left=%0d x=%0d, required 0 105", left, head_x); end
        base = wr_count;
        vs_pulses(4);
        cycles(5);
        checks++; if (game_over !== 1'b1 || head_x !== 16'd105) begin errors++;
            $display("FAIL dead_state go=%b x=%0d, required 1 105", game_over, head_x); end
        vs_pulses(4);
        checks++; if (wr_count !== base || bus.write !== 1'b0) begin errors++;
            $display("FAIL dead_quiet writes=%0d write=%b, required 0 0", wr_count - base, bus.write); end
        push_burst(2, 50, 40);
        restart = 1'b1;
        cycles(1);
        restart = 1'b0;
        wait_drain(left);
        checks++; if (left !== 0 || game_over !== 1'b0) begin errors++;
            $display("FAIL restart_burst left=%0d go=%b, required 0 0", left, game_over); end
        checks++; if (head_x !== 16'd50 || head_y !== 16'd40 || length !== 16'd2) begin errors++;
            $display("FAIL restart_head x=%0d y=%0d len=%0d, required 50 40 2", head_x, head_y, length); end
    endtask

    task automatic test_overrun;
        int left;
        int base;
        base = wr_count;
        bus.waitrequest = 1'b1;
        push_burst(2, 51, 40);
        push_burst(2, 52, 40);
        vs_pulses(12);
        checks++; if (overrun !== 1'b1 || wr_count !== base) begin errors++;
            $display("FAIL overrun_set ov=%b writes=%0d, required 1 0", overrun, wr_count - base); end
        bus.waitrequest = 1'b0;
        wait_drain(left);
        checks++; if (left !== 0 || head_x !== 16'd52 || overrun !== 1'b1) begin errors++;
            $display("FAIL overrun_after left=%0d x=%0d ov=%b, required 0 52 1", left, head_x, overrun); end
    endtask

    initial begin
        test_reset();
        test_steps();
        test_turn();
        test_waitrequest();
        test_grow();
        test_dead();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
